// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter and sequencing stage behind the instruction decoder. It
// selects the next fetch address (sequential, jump, conditional branch), keeps
// the registered zero/negative flags that conditional branches test, and owns
// the run / wait-for-input / accept / halt state of the processor.
//
// Ports
//   clock         in   system clock, rising-edge active
//   reset         in   asynchronous, active-low; forces all state to reset values
//   jump          in   unconditional jump request
//   bzero         in   branch if registered zero flag is set
//   bnegative     in   branch if registered negative flag is set
//   mainAddress   in   jump / branch target [ADDR_WIDTH]
//   enable        in   flag-capture strobe (ALU and pre-branch instructions)
//   HLT           in   halt request
//   inRequest     in   current instruction is an input instruction
//   aluZero       in   ALU result is zero
//   aluNegative   in   ALU result MSB
//   inConfirm     in   asynchronous operator confirm button, active-high
//   pc            out  current instruction address [ADDR_WIDTH]
//   zeroFlag      out  registered zero flag
//   negativeFlag  out  registered negative flag
//   halted        out  processor stopped
//   waitingInput  out  waiting for operator confirmation
//   stall         out  datapath must suppress register / RAM writes
//   inAccept      out  one-cycle strobe: commit the input value
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jump,
    input  logic                  bzero,
    input  logic                  bnegative,
    input  logic [ADDR_WIDTH-1:0] mainAddress,
    input  logic                  enable,
    input  logic                  HLT,
    input  logic                  inRequest,
    input  logic                  aluZero,
    input  logic                  aluNegative,
    input  logic                  inConfirm,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  zeroFlag,
    output logic                  negativeFlag,
    output logic                  halted,
    output logic                  waitingInput,
    output logic                  stall,
    output logic                  inAccept
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_IN = 2'd1,
        S_ACCEPT  = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_zero;
    logic                  r_neg;

    // Two synchronizer flops followed by the edge-history flop.
    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;

    logic                  w_confirm_edge;
    logic                  w_branch_taken;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_confirm_edge = r_sync2 & ~r_sync_prev;
    // Branches test the flags as held before this edge; same-cycle ALU status
    // is deliberately not bypassed.
    assign w_branch_taken = jump | (bzero & r_zero) | (bnegative & r_neg);
    assign w_pc_inc       = r_pc + ADDR_WIDTH'(1);

    // The edge detector runs in every state so that a button already held
    // when WAIT_IN is entered shows no edge and must be pressed again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            r_sync1     <= inConfirm;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_pc    <= RESET_ADDR;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (enable) begin
                        r_zero <= aluZero;
                        r_neg  <= aluNegative;
                    end
                    if (HLT) begin
                        r_state <= S_HALT;
                    end else if (inRequest) begin
                        r_state <= S_WAIT_IN;
                    end else if (w_branch_taken) begin
                        r_pc <= mainAddress;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                S_WAIT_IN: begin
                    if (w_confirm_edge) begin
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_RUN;
                end
                S_HALT: begin
                    // Left only through reset.
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // Status outputs decode the state register directly, so they fall with
    // reset asynchronously and have no input-to-output combinational path.
    assign pc           = r_pc;
    assign zeroFlag     = r_zero;
    assign negativeFlag = r_neg;
    assign halted       = (r_state == S_HALT);
    assign waitingInput = (r_state == S_WAIT_IN);
    assign stall        = (r_state == S_WAIT_IN) || (r_state == S_HALT);
    assign inAccept     = (r_state == S_ACCEPT);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. A table of control vectors with
// expected outputs covers sequential fetch, wrap, jumps and branches; hand
// sequences cover the input handshake, halt and asynchronous reset. Expected
// output words are queued when a cycle is driven and popped when that cycle's
// result is sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int AW = 10;

    logic          clock;
    logic          reset;
    logic          jump;
    logic          bzero;
    logic          bnegative;
    logic [AW-1:0] mainAddress;
    logic          enable;
    logic          HLT;
    logic          inRequest;
    logic          aluZero;
    logic          aluNegative;
    logic          inConfirm;
    logic [AW-1:0] pc;
    logic          zeroFlag;
    logic          negativeFlag;
    logic          halted;
    logic          waitingInput;
    logic          stall;
    logic          inAccept;

    pc_sequencer #(
        .ADDR_WIDTH (AW),
        .RESET_ADDR ('0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .jump         (jump),
        .bzero        (bzero),
        .bnegative    (bnegative),
        .mainAddress  (mainAddress),
        .enable       (enable),
        .HLT          (HLT),
        .inRequest    (inRequest),
        .aluZero      (aluZero),
        .aluNegative  (aluNegative),
        .inConfirm    (inConfirm),
        .pc           (pc),
        .zeroFlag     (zeroFlag),
        .negativeFlag (negativeFlag),
        .halted       (halted),
        .waitingInput (waitingInput),
        .stall        (stall),
        .inAccept     (inAccept)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output word layout: {pc[9:0], zf, nf, halted, waiting, stall, accept}
    typedef struct {
        logic          jmp;
        logic          bz;
        logic          bn;
        logic [AW-1:0] addr;
        logic          en;
        logic          hlt;
        logic          inr;
        logic          az;
        logic          an;
        logic [AW-1:0] e_pc;
        logic          e_zf;
        logic          e_nf;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    vec_t        vecs[19];

    function automatic logic [15:0] exp_word(input logic [AW-1:0] p, input logic zf,
                                             input logic nf, input logic h, input logic w,
                                             input logic s, input logic a);
        return {p, zf, nf, h, w, s, a};
    endfunction

    function automatic logic [15:0] dut_word();
        return {pc, zeroFlag, negativeFlag, halted, waitingInput, stall, inAccept};
    endfunction

    function automatic vec_t mk(input logic j, input logic bz, input logic bn,
                                input int a, input logic en, input logic az,
                                input logic an, input int epc, input logic ezf,
                                input logic enf);
        vec_t v;
        v.jmp  = j;   v.bz  = bz;  v.bn  = bn;  v.addr = AW'(a);
        v.en   = en;  v.hlt = 1'b0; v.inr = 1'b0;
        v.az   = az;  v.an  = an;
        v.e_pc = AW'(epc); v.e_zf = ezf; v.e_nf = enf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of controls just after a falling edge, queue the expected
    // output word, and compare it at the next falling edge.
    task automatic step(input string name, input logic j, input logic bz, input logic bn,
                        input logic [AW-1:0] a, input logic en, input logic hlt,
                        input logic inr, input logic az, input logic an,
                        input logic [15:0] exp);
        logic [15:0] e;
        jump = j; bzero = bz; bnegative = bn; mainAddress = a;
        enable = en; HLT = hlt; inRequest = inr; aluZero = az; aluNegative = an;
        sb_q.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        e = sb_q.pop_front();
        check(name, 32'(dut_word()), 32'(e));
    endtask

    task automatic nop(input string name, input logic [15:0] exp);
        step(name, 0, 0, 0, '0, 0, 0, 0, 0, 0, exp);
    endtask

    // Waits (bounded) for the accept strobe, returning at the falling edge
    // where it is visible.
    task automatic wait_accept(input string name);
        int k;
        k = 0;
        while (!inAccept && k < 8) begin
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        check(name, 32'(inAccept), 32'd1);
    endtask

    task automatic pulse_confirm(input string name, input logic [AW-1:0] p,
                                 input logic zf, input logic nf);
        inConfirm = 1'b1;
        nop(name, exp_word(p, zf, nf, 0, 1, 1, 0));
        inConfirm = 1'b0;
    endtask

    // Assert reset away from any clock edge, check the outputs clear before
    // the next edge, then release on a falling edge.
    task automatic async_reset(input string name);
        #2 reset = 1'b0;
        #1 check(name, 32'(dut_word()), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; jump = 0; bzero = 0; bnegative = 0; mainAddress = '0;
        enable = 0; HLT = 0; inRequest = 0; aluZero = 0; aluNegative = 0;
        inConfirm = 0;

        //            j  bz bn addr  en az an  pc    zf nf
        vecs[0]  = mk(0, 0, 0, 0,    0, 0, 0,  1,    0, 0);
        vecs[1]  = mk(0, 0, 0, 0,    0, 0, 0,  2,    0, 0);
        vecs[2]  = mk(0, 0, 0, 0,    0, 0, 0,  3,    0, 0);
        vecs[3]  = mk(0, 0, 0, 0,    0, 0, 0,  4,    0, 0);
        vecs[4]  = mk(0, 0, 0, 0,    0, 0, 0,  5,    0, 0);
        vecs[5]  = mk(1, 0, 0, 1023, 0, 0, 0,  1023, 0, 0);  // jump to top
        vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0,  0,    0, 0);  // wrap
        vecs[7]  = mk(0, 0, 0, 0,    1, 1, 0,  1,    1, 0);  // capture Z
        vecs[8]  = mk(0, 1, 0, 300,  0, 0, 0,  300,  1, 0);  // bzero taken
        vecs[9]  = mk(0, 0, 0, 0,    1, 0, 0,  301,  0, 0);  // capture !Z
        vecs[10] = mk(0, 1, 0, 500,  0, 0, 0,  302,  0, 0);  // bzero untaken
        vecs[11] = mk(0, 0, 0, 0,    1, 0, 1,  303,  0, 1);  // capture N
        vecs[12] = mk(0, 0, 1, 40,   0, 0, 0,  40,   0, 1);  // bneg taken
        vecs[13] = mk(0, 0, 0, 0,    0, 1, 0,  41,   0, 1);  // flags hold
        vecs[14] = mk(0, 0, 0, 0,    0, 0, 1,  42,   0, 1);  // flags hold
        vecs[15] = mk(0, 1, 0, 600,  1, 1, 0,  43,   1, 0);  // no bypass
        vecs[16] = mk(0, 1, 0, 600,  0, 0, 0,  600,  1, 0);  // now taken
        vecs[17] = mk(0, 0, 1, 5,    0, 0, 0,  601,  1, 0);  // bneg untaken
        vecs[18] = mk(1, 1, 0, 7,    0, 0, 0,  7,    1, 0);  // jump

        repeat (2) @(negedge clock);
        check("reset_state", 32'(dut_word()), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step($sformatf("vec%0d", i), vecs[i].jmp, vecs[i].bz, vecs[i].bn,
                 vecs[i].addr, vecs[i].en, vecs[i].hlt, vecs[i].inr,
                 vecs[i].az, vecs[i].an,
                 exp_word(vecs[i].e_pc, vecs[i].e_zf, vecs[i].e_nf, 0, 0, 0, 0));
        end

        // Input handshake at pc = 7 (flags Z=1, N=0).
        step("in_req", 0, 0, 0, '0, 0, 0, 1, 0, 0, exp_word(7, 1, 0, 0, 1, 1, 0));
        nop("in_wait0", exp_word(7, 1, 0, 0, 1, 1, 0));
        nop("in_wait1", exp_word(7, 1, 0, 0, 1, 1, 0));
        pulse_confirm("in_press", 7, 1, 0);
        wait_accept("in_accept_seen");
        check("in_accept_word", 32'(dut_word()), 32'(exp_word(7, 1, 0, 0, 0, 0, 1)));
        nop("in_after_accept", exp_word(8, 1, 0, 0, 0, 0, 0));
        nop("in_run_again", exp_word(9, 1, 0, 0, 0, 0, 0));

        // Button held before the input instruction: no accept until re-pressed.
        inConfirm = 1'b1;
        for (int i = 0; i < 4; i++)
            nop($sformatf("held_run%0d", i), exp_word(AW'(10 + i), 1, 0, 0, 0, 0, 0));
        step("held_req", 0, 0, 0, '0, 0, 0, 1, 0, 0, exp_word(13, 1, 0, 0, 1, 1, 0));
        for (int i = 0; i < 5; i++)
            nop($sformatf("held_wait%0d", i), exp_word(13, 1, 0, 0, 1, 1, 0));
        inConfirm = 1'b0;
        for (int i = 0; i < 4; i++)
            nop($sformatf("released_wait%0d", i), exp_word(13, 1, 0, 0, 1, 1, 0));
        pulse_confirm("repress", 13, 1, 0);
        wait_accept("repress_accept_seen");
        check("repress_accept_word", 32'(dut_word()), 32'(exp_word(13, 1, 0, 0, 0, 0, 1)));
        nop("repress_after", exp_word(14, 1, 0, 0, 0, 0, 0));

        // Halt wins over jump; pc and flags freeze; everything else ignored.
        step("to_20", 1, 0, 0, AW'(20), 0, 0, 0, 0, 0, exp_word(20, 1, 0, 0, 0, 0, 0));
        step("halt_jump", 1, 0, 0, AW'(99), 0, 1, 0, 0, 0, exp_word(20, 1, 0, 1, 0, 1, 0));
        for (int i = 0; i < 50; i++) begin
            inConfirm = 1'($urandom_range(0, 1));
            step($sformatf("halt%0d", i), 1, 1, 1, AW'($urandom_range(0, 1023)), 1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1,
                 exp_word(20, 1, 0, 1, 0, 1, 0));
        end
        inConfirm = 1'b0;

        // Reset during HALT, then during WAIT_IN, then during ACCEPT.
        async_reset("rst_in_halt");
        nop("run_after_halt_rst", exp_word(1, 0, 0, 0, 0, 0, 0));
        step("req_b", 0, 0, 0, '0, 0, 0, 1, 0, 0, exp_word(1, 0, 0, 0, 1, 1, 0));
        async_reset("rst_in_wait");
        nop("run_after_wait_rst", exp_word(1, 0, 0, 0, 0, 0, 0));
        step("req_c", 0, 0, 0, '0, 0, 0, 1, 0, 0, exp_word(1, 0, 0, 0, 1, 1, 0));
        pulse_confirm("press_c", 1, 0, 0);
        wait_accept("accept_c_seen");
        async_reset("rst_in_accept");
        nop("run_after_accept_rst", exp_word(1, 0, 0, 0, 0, 0, 0));

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
